// File: rtl/fighter_action_ctrl.sv
// fighter_action_ctrl: per-player action scheduler. Arbitrates walk, jump,
// attack, block and hit-stun into one action state and drives the movement
// block and the collision/damage logic. All sequencing advances on SCEN ticks;
// outputs are registered together with the state so they change only on ticks.
module fighter_action_ctrl #(
    parameter int CNT_WIDTH      = 5,
    parameter int ATK_STARTUP    = 3,
    parameter int ATK_ACTIVE     = 2,
    parameter int ATK_RECOVERY   = 5,
    parameter int HITSTUN_FRAMES = 12,
    parameter int AIR_TIMEOUT    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       btn_block,
    input  logic       hit_received,
    input  logic       jump_active,
    output logic       move_enable,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       attack_hitbox,
    output logic       blocking,
    output logic       blocked_hit,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WALK        = 3'd1;
    localparam logic [2:0] S_AIR         = 3'd2;
    localparam logic [2:0] S_ATK_START   = 3'd3;
    localparam logic [2:0] S_ATK_HIT     = 3'd4;
    localparam logic [2:0] S_ATK_RECOVER = 3'd5;
    localparam logic [2:0] S_BLOCK       = 3'd6;
    localparam logic [2:0] S_HITSTUN     = 3'd7;

    // Countdown reload values: each timed state lasts exactly its parameter
    // in frames because it leaves on the tick that finds the count at zero.
    localparam logic [CNT_WIDTH-1:0] LD_STARTUP  = CNT_WIDTH'(ATK_STARTUP - 1);
    localparam logic [CNT_WIDTH-1:0] LD_ACTIVE   = CNT_WIDTH'(ATK_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] LD_RECOVERY = CNT_WIDTH'(ATK_RECOVERY - 1);
    localparam logic [CNT_WIDTH-1:0] LD_HITSTUN  = CNT_WIDTH'(HITSTUN_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0] LD_AIR      = CNT_WIDTH'(AIR_TIMEOUT - 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 seen_air_q, seen_air_d;
    logic                 jump_prev_q, atk_prev_q;
    logic                 move_enable_q, move_left_q, move_left_d;
    logic                 move_right_q, move_right_d;
    logic                 jump_q, jump_d;
    logic                 attack_hitbox_q, blocking_q;
    logic                 blocked_hit_q, blocked_hit_d;

    logic atk_edge, jmp_edge, only_left, only_right;

    assign atk_edge   = btn_attack & ~atk_prev_q;
    assign jmp_edge   = btn_jump & ~jump_prev_q;
    assign only_left  = btn_left & ~btn_right;
    assign only_right = btn_right & ~btn_left;

    // Next-state arbitration: hit > attack edge > block > jump edge > walk.
    always_comb begin
        state_d       = state_q;
        cnt_d         = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        seen_air_d    = 1'b0;
        jump_d        = 1'b0;
        move_left_d   = 1'b0;
        move_right_d  = 1'b0;
        blocked_hit_d = 1'b0;
        if (hit_received) begin
            if (state_q == S_BLOCK) begin
                blocked_hit_d = 1'b1;
            end else begin
                state_d = S_HITSTUN;
                cnt_d   = LD_HITSTUN;
            end
        end else begin
            case (state_q)
                S_IDLE, S_WALK: begin
                    if (atk_edge) begin
                        state_d = S_ATK_START;
                        cnt_d   = LD_STARTUP;
                    end else if (btn_block) begin
                        state_d = S_BLOCK;
                    end else if (jmp_edge) begin
                        state_d      = S_AIR;
                        cnt_d        = LD_AIR;
                        jump_d       = 1'b1;
                        move_left_d  = only_left;
                        move_right_d = only_right;
                    end else if (only_left || only_right) begin
                        state_d      = S_WALK;
                        move_left_d  = only_left;
                        move_right_d = only_right;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_AIR: begin
                    if (seen_air_q && !jump_active) begin
                        state_d = S_IDLE;
                    end else if (!seen_air_q && !jump_active && cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        seen_air_d = seen_air_q | jump_active;
                    end
                end
                S_ATK_START: begin
                    if (cnt_q == '0) begin
                        state_d = S_ATK_HIT;
                        cnt_d   = LD_ACTIVE;
                    end
                end
                S_ATK_HIT: begin
                    if (cnt_q == '0) begin
                        state_d = S_ATK_RECOVER;
                        cnt_d   = LD_RECOVERY;
                    end
                end
                S_ATK_RECOVER: begin
                    if (cnt_q == '0) state_d = S_IDLE;
                end
                S_BLOCK: begin
                    if (!btn_block) state_d = S_IDLE;
                end
                S_HITSTUN: begin
                    if (cnt_q == '0) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counter, edge history and registered output decode; all hold
    // between ticks and clear asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            seen_air_q      <= 1'b0;
            jump_prev_q     <= 1'b0;
            atk_prev_q      <= 1'b0;
            move_enable_q   <= 1'b1;
            move_left_q     <= 1'b0;
            move_right_q    <= 1'b0;
            jump_q          <= 1'b0;
            attack_hitbox_q <= 1'b0;
            blocking_q      <= 1'b0;
            blocked_hit_q   <= 1'b0;
        end else if (SCEN) begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            seen_air_q      <= seen_air_d;
            jump_prev_q     <= btn_jump;
            atk_prev_q      <= btn_attack;
            move_enable_q   <= !(state_d == S_ATK_START || state_d == S_ATK_HIT ||
                                 state_d == S_ATK_RECOVER || state_d == S_BLOCK);
            move_left_q     <= move_left_d;
            move_right_q    <= move_right_d;
            jump_q          <= jump_d;
            attack_hitbox_q <= (state_d == S_ATK_HIT);
            blocking_q      <= (state_d == S_BLOCK);
            blocked_hit_q   <= blocked_hit_d;
        end
    end

    assign state         = state_q;
    assign move_enable   = move_enable_q;
    assign move_left     = move_left_q;
    assign move_right    = move_right_q;
    assign jump          = jump_q;
    assign attack_hitbox = attack_hitbox_q;
    assign blocking      = blocking_q;
    assign blocked_hit   = blocked_hit_q;

endmodule

// File: tb/tb_fighter_action_ctrl.sv
// Bench for fighter_action_ctrl: directed scenarios followed by random frames,
// every frame compared against a frame-counting reference model.
module tb_fighter_action_ctrl;

    localparam int ATK_STARTUP    = 3;
    localparam int ATK_ACTIVE     = 2;
    localparam int ATK_RECOVERY   = 5;
    localparam int HITSTUN_FRAMES = 12;
    localparam int AIR_TIMEOUT    = 3;

    localparam int IDLE = 0, WALK = 1, AIR = 2, ASTART = 3, AHIT = 4,
                   AREC = 5, BLOCK = 6, HSTUN = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scen = 1'b0;
    always #5 clk = ~clk;

    logic b_left = 0, b_right = 0, b_jump = 0, b_atk = 0, b_block = 0, b_hit = 0, b_ja = 0;
    logic move_enable, move_left, move_right, jump, attack_hitbox, blocking, blocked_hit;
    logic [2:0] state;

    fighter_action_ctrl dut (
        .clk(clk), .reset(reset), .SCEN(scen),
        .btn_left(b_left), .btn_right(b_right), .btn_jump(b_jump),
        .btn_attack(b_atk), .btn_block(b_block),
        .hit_received(b_hit), .jump_active(b_ja),
        .move_enable(move_enable), .move_left(move_left), .move_right(move_right),
        .jump(jump), .attack_hitbox(attack_hitbox), .blocking(blocking),
        .blocked_hit(blocked_hit), .state(state)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    // m_age counts ticks spent in the current state since it was entered;
    // a timed state of length D is left on the tick where m_age reaches D.
    int m_state, m_age;
    bit m_seen, m_pj, m_pa;
    bit e_me, e_ml, e_mr, e_jump, e_hb, e_blk, e_bh;

    task automatic model_reset();
        m_state = IDLE; m_age = 0; m_seen = 0; m_pj = 0; m_pa = 0;
        e_me = 1; e_ml = 0; e_mr = 0; e_jump = 0; e_hb = 0; e_blk = 0; e_bh = 0;
    endtask

    task automatic model_step();
        bit aedge, jedge, one_l, one_r, restart;
        int nxt;
        aedge = b_atk && !m_pa;
        jedge = b_jump && !m_pj;
        one_l = b_left && !b_right;
        one_r = b_right && !b_left;
        e_jump = 0; e_bh = 0; e_ml = 0; e_mr = 0;
        nxt = m_state; restart = 0;
        m_age = m_age + 1;
        if (b_hit) begin
            if (m_state == BLOCK) e_bh = 1;
            else begin nxt = HSTUN; restart = 1; end
        end else begin
            case (m_state)
                IDLE, WALK: begin
                    if (aedge) nxt = ASTART;
                    else if (b_block) nxt = BLOCK;
                    else if (jedge) begin nxt = AIR; e_jump = 1; e_ml = one_l; e_mr = one_r; end
                    else if (one_l || one_r) begin nxt = WALK; e_ml = one_l; e_mr = one_r; end
                    else nxt = IDLE;
                end
                AIR: begin
                    if (m_seen ? !b_ja : (!b_ja && m_age >= AIR_TIMEOUT)) nxt = IDLE;
                    else m_seen = m_seen | b_ja;
                end
                ASTART: if (m_age == ATK_STARTUP) nxt = AHIT;
                AHIT:   if (m_age == ATK_ACTIVE) nxt = AREC;
                AREC:   if (m_age == ATK_RECOVERY) nxt = IDLE;
                BLOCK:  if (!b_block) nxt = IDLE;
                HSTUN:  if (m_age == HITSTUN_FRAMES) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
        if (nxt != m_state || restart) begin m_age = 0; m_seen = 0; end
        m_state = nxt;
        e_me  = !(nxt == ASTART || nxt == AHIT || nxt == AREC || nxt == BLOCK);
        e_hb  = (nxt == AHIT);
        e_blk = (nxt == BLOCK);
        m_pj = b_jump;
        m_pa = b_atk;
    endtask

    // ---------------- scoreboard / checks ----------------
    function automatic logic [9:0] obs_vec();
        return {state, move_enable, move_left, move_right, jump, attack_hitbox, blocking, blocked_hit};
    endfunction

    function automatic logic [9:0] exp_vec();
        return {3'(m_state), e_me, e_ml, e_mr, e_jump, e_hb, e_blk, e_bh};
    endfunction

    task automatic check_outputs(input string tag);
        logic [9:0] o, e;
        o = obs_vec();
        e = exp_vec();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s obs={st,me,ml,mr,jmp,hb,blk,bh}=%b exp=%b", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    // ---------------- driver ----------------
    // One frame = one SCEN cycle followed by one idle cycle; checked at the
    // falling edge after the tick.
    task automatic frame(input string tag, input bit l, input bit r, input bit j,
                         input bit a, input bit blk, input bit h, input bit ja);
        @(negedge clk);
        b_left = l; b_right = r; b_jump = j; b_atk = a; b_block = blk; b_hit = h; b_ja = ja;
        scen = 1'b1;
        model_step();
        @(negedge clk);
        scen = 1'b0;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; scen = 1'b0;
        b_left = 0; b_right = 0; b_jump = 0; b_atk = 0; b_block = 0; b_hit = 0; b_ja = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hb_cnt, me0_cnt, hs_cnt, k;
        bit l, r, j, a, blk, h, ja;

        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        assert (obs_vec() === 10'b000_1_000000) else begin
            fails++;
            $error("FAIL reset_values obs=%b exp=%b", obs_vec(), 10'b000_1_000000);
        end

        // Walk right, both directions, release.
        repeat (4) frame("walk_right", 0, 1, 0, 0, 0, 0, 0);
        repeat (2) frame("both_dirs", 1, 1, 0, 0, 0, 0, 0);
        frame("release", 0, 0, 0, 0, 0, 0, 0);

        // Attack from IDLE: hitbox frames and movement lock count.
        hb_cnt = 0; me0_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            frame("attack_seq", 0, 0, 0, 1, 0, 0, 0);
            if (attack_hitbox === 1'b1) hb_cnt++;
            if (move_enable === 1'b0) me0_cnt++;
        end
        check_int("attack_hitbox_frames", hb_cnt, ATK_ACTIVE);
        check_int("attack_lock_frames", me0_cnt, ATK_STARTUP + ATK_ACTIVE + ATK_RECOVERY);
        frame("attack_release", 0, 0, 0, 0, 0, 0, 0);

        // Jump with left held, long airtime, attack edges ignored.
        frame("jump_left", 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            frame("air_hold", 0, 0, 0, i[0], 0, 0, 1);
        frame("air_land", 0, 0, 0, 0, 0, 0, 0);
        frame("after_land", 0, 0, 0, 0, 0, 0, 0);
        // Jump that never leaves the ground.
        frame("jump_no_air", 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) frame("air_timeout", 0, 0, 0, 0, 0, 0, 0);

        // Hit during ATK_HIT, re-hit extends hit-stun.
        frame("atk2_edge", 0, 0, 0, 1, 0, 0, 0);
        k = 0;
        while (m_state != AHIT && k < 8) begin frame("atk2_wait", 0, 0, 0, 1, 0, 0, 0); k++; end
        check_int("reach_atk_hit", state, AHIT);
        hs_cnt = 0;
        frame("hit_in_atk", 0, 0, 0, 0, 0, 1, 0);
        if (state === 3'(HSTUN)) hs_cnt++;
        check_int("hit_drops_hitbox", attack_hitbox, 0);
        for (int i = 0; i < 5; i++) begin
            frame("hitstun", 0, 0, 0, 0, 0, 0, 0);
            if (state === 3'(HSTUN)) hs_cnt++;
        end
        frame("rehit", 0, 0, 0, 0, 0, 1, 0);
        if (state === 3'(HSTUN)) hs_cnt++;
        for (int i = 0; i < 14; i++) begin
            frame("hitstun2", 0, 0, 0, 0, 0, 0, 0);
            if (state === 3'(HSTUN)) hs_cnt++;
        end
        check_int("hitstun_total_frames", hs_cnt, 6 + HITSTUN_FRAMES);

        // Simultaneous hit and attack edge: hit wins.
        frame("hit_vs_attack", 0, 0, 0, 1, 0, 1, 0);
        repeat (13) frame("hit_vs_attack_wait", 0, 0, 0, 0, 0, 0, 0);

        // Block with a blocked hit, then release.
        repeat (2) frame("block_hold", 0, 0, 0, 0, 1, 0, 0);
        frame("block_hit", 0, 0, 0, 0, 1, 1, 0);
        frame("block_after_hit", 0, 0, 0, 0, 1, 0, 0);
        frame("block_release", 0, 0, 0, 0, 0, 0, 0);
        frame("idle_again", 0, 1, 0, 0, 0, 0, 0);

        // SCEN low: button activity must not change anything.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_left = 1'($urandom_range(0, 1)); b_right = 1'($urandom_range(0, 1));
            b_jump = 1'($urandom_range(0, 1)); b_atk = 1'($urandom_range(0, 1));
            b_block = 1'($urandom_range(0, 1)); b_hit = 1'($urandom_range(0, 1));
            check_outputs("scen_low_hold");
        end

        // Asynchronous reset in the middle of ATK_HIT.
        frame("atk3_pre", 0, 0, 0, 0, 0, 0, 0);
        frame("atk3_edge", 0, 0, 0, 1, 0, 0, 0);
        k = 0;
        while (m_state != AHIT && k < 8) begin frame("atk3_wait", 0, 0, 0, 1, 0, 0, 0); k++; end
        check_int("atk3_hitbox_live", attack_hitbox, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset_mid_hit");
        do_reset();

        // Random frames.
        l = 0; r = 0; j = 0; a = 0; blk = 0; ja = 0;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 3) == 0) l = ~l;
            if ($urandom_range(0, 3) == 0) r = ~r;
            if ($urandom_range(0, 2) == 0) j = ~j;
            if ($urandom_range(0, 3) == 0) a = ~a;
            if ($urandom_range(0, 5) == 0) blk = ~blk;
            if ($urandom_range(0, 3) == 0) ja = ~ja;
            h = ($urandom_range(0, 14) == 0);
            frame("random", l, r, j, a, blk, h, ja);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
